// File: rtl/la_clkgate_seq.sv
// la_clkgate_seq -- clock-gate sequencer for N gated clock domains.
//
// Wake-ups are serialised with a programmable stagger to bound supply di/dt.
// Each requester is acknowledged once its gated clock has settled. A domain
// is gated off after it has been idle for HOLD consecutive cycles.
// The block lives in the always-on clock domain, next to the gate cells.
//
// Ports:
//   clk      always-on clock
//   nreset   synchronous active-low reset
//   req      per-domain clock request (level)
//   idle     per-domain idle indication from the domain logic
//   test_en  DFT override, forces every clock enable on
//   en       clock enables to the gate cells (en_q | {N{test_en}})
//   ack      per-domain clock stable, 2 cycles after en_q rises
//   busy     wake sequencing in progress
module la_clkgate_seq #(
    parameter int N       = 4,
    parameter int STAGGER = 4,
    parameter int HOLD    = 16,
    parameter int CW      = 8
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [N-1:0] req,
    input  logic [N-1:0] idle,
    input  logic         test_en,
    output logic [N-1:0] en,
    output logic [N-1:0] ack,
    output logic         busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_PEND,
        ST_SETTLE,
        ST_ON
    } state_t;

    state_t          state    [N];
    logic [CW-1:0]   idle_cnt [N];
    logic [N-1:0]    en_q;
    logic [N-1:0]    ack_q;
    logic [N-1:0]    settle_q;
    logic [CW-1:0]   timer;
    logic [PW-1:0]   ptr;

    logic [N-1:0]    cand;
    logic [N-1:0]    seq_vec;
    logic            grant_vld;
    logic            grant;
    logic [PW-1:0]   grant_idx;
    int unsigned     idx;

    // A PEND domain whose request has already dropped is not eligible, so a
    // withdrawn request never produces an enable pulse.
    always_comb begin
        cand    = '0;
        seq_vec = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand[i]    = (state[i] == ST_PEND) && req[i];
            seq_vec[i] = (state[i] == ST_PEND) || (state[i] == ST_SETTLE);
        end
    end

    // Circular scan starting at ptr; first eligible index wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!grant_vld && cand[PW'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = PW'(idx);
            end
        end
    end

    assign grant = grant_vld && (timer == '0);

    always_ff @(posedge clk) begin
        if (!nreset) begin
            en_q     <= '0;
            ack_q    <= '0;
            settle_q <= '0;
            timer    <= '0;
            ptr      <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                state[i]    <= ST_OFF;
                idle_cnt[i] <= '0;
            end
        end else begin
            if (grant) begin
                timer <= CW'(STAGGER - 1);
                ptr   <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
            end else if (timer != '0) begin
                timer <= timer - CW'(1);
            end

            for (int unsigned i = 0; i < N; i++) begin
                case (state[i])
                    ST_OFF: begin
                        if (req[i]) state[i] <= ST_PEND;
                    end
                    ST_PEND: begin
                        if (grant && (grant_idx == PW'(i))) begin
                            en_q[i]     <= 1'b1;
                            settle_q[i] <= 1'b0;
                            state[i]    <= ST_SETTLE;
                        end else if (!req[i]) begin
                            state[i] <= ST_OFF;
                        end
                    end
                    // settle_q marks the first settle cycle as spent.
                    ST_SETTLE: begin
                        if (settle_q[i]) begin
                            ack_q[i]    <= 1'b1;
                            idle_cnt[i] <= '0;
                            state[i]    <= ST_ON;
                        end else begin
                            settle_q[i] <= 1'b1;
                        end
                    end
                    ST_ON: begin
                        if (!req[i] && idle[i]) begin
                            if (idle_cnt[i] == CW'(HOLD - 1)) begin
                                en_q[i]     <= 1'b0;
                                ack_q[i]    <= 1'b0;
                                idle_cnt[i] <= '0;
                                state[i]    <= ST_OFF;
                            end else begin
                                idle_cnt[i] <= idle_cnt[i] + CW'(1);
                            end
                        end else begin
                            idle_cnt[i] <= '0;
                        end
                    end
                    default: state[i] <= ST_OFF;
                endcase
            end
        end
    end

    // test_en only reaches the gate cells; the gate cell latch absorbs it.
    assign en   = en_q | {N{test_en}};
    assign ack  = ack_q;
    assign busy = (|seq_vec) || (timer != '0);

endmodule

// File: tb/tb_la_clkgate_seq.sv
// Testbench for la_clkgate_seq (N=4, STAGGER=4, HOLD=16).
// Stimulus pushes expected {en, ack, busy} snapshots tagged with the cycle
// they must appear in; a negedge monitor pops and compares them.
module tb_la_clkgate_seq;

    logic       clk = 1'b0;
    logic       nreset;
    logic [3:0] req;
    logic [3:0] idle;
    logic       test_en;
    logic [3:0] en;
    logic [3:0] ack;
    logic       busy;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  en;
        logic [3:0]  ack;
        logic        busy;
        string       name;
    } exp_t;

    exp_t q[$];

    la_clkgate_seq #(.N(4), .STAGGER(4), .HOLD(16), .CW(8)) dut (
        .clk     (clk),
        .nreset  (nreset),
        .req     (req),
        .idle    (idle),
        .test_en (test_en),
        .en      (en),
        .ack     (ack),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
            end else if (en !== e.en || ack !== e.ack || busy !== e.busy) begin
                errors++;
                $display("FAIL %s @%0d: got en=%b ack=%b busy=%b, want en=%b ack=%b busy=%b",
                         e.name, cyc, en, ack, busy, e.en, e.ack, e.busy);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expect_at(input int unsigned off, input logic [3:0] e_en,
                             input logic [3:0] e_ack, input logic e_busy, input string name);
        exp_t e;
        e.cyc  = cyc + off;
        e.en   = e_en;
        e.ack  = e_ack;
        e.busy = e_busy;
        e.name = name;
        q.push_back(e);
    endtask

    initial begin
        nreset  = 1'b0;
        req     = 4'hF;
        idle    = 4'h0;
        test_en = 1'b0;

        // Reset with all requests high
        tick(2);
        expect_at(0, 4'h0, 4'h0, 1'b0, "reset");
        tick(1);

        // Release: contention, grants 0,1,2,3 spaced 4 cycles
        nreset = 1'b1;
        expect_at(1,  4'h0, 4'h0, 1'b1, "cont_pend");
        expect_at(2,  4'h1, 4'h0, 1'b1, "cont_g0");
        expect_at(4,  4'h1, 4'h1, 1'b1, "cont_ack0");
        expect_at(5,  4'h1, 4'h1, 1'b1, "cont_gap");
        expect_at(6,  4'h3, 4'h1, 1'b1, "cont_g1");
        expect_at(10, 4'h7, 4'h3, 1'b1, "cont_g2");
        expect_at(14, 4'hF, 4'h7, 1'b1, "cont_g3");
        expect_at(16, 4'hF, 4'hF, 1'b1, "cont_ack3");
        expect_at(17, 4'hF, 4'hF, 1'b0, "cont_idle");
        tick(18);

        // All domains idle for HOLD cycles -> gate off
        req  = 4'h0;
        idle = 4'hF;
        expect_at(15, 4'hF, 4'hF, 1'b0, "hold_15");
        expect_at(16, 4'h0, 4'h0, 1'b0, "hold_off");
        tick(17);

        // Single wake of domain 2
        req = 4'h4;
        expect_at(1, 4'h0, 4'h0, 1'b1, "wake_pend");
        expect_at(2, 4'h4, 4'h0, 1'b1, "wake_en");
        expect_at(3, 4'h4, 4'h0, 1'b1, "wake_settle");
        expect_at(4, 4'h4, 4'h4, 1'b1, "wake_ack");
        expect_at(5, 4'h4, 4'h4, 1'b0, "wake_busy_clr");
        tick(6);

        // Gate-off with idle=0 pulse on the 10th counting edge
        req = 4'h0;
        expect_at(16, 4'h4, 4'h4, 1'b0, "restart_hold");
        expect_at(25, 4'h4, 4'h4, 1'b0, "restart_25");
        expect_at(26, 4'h0, 4'h0, 1'b0, "restart_off");
        tick(9);
        idle = 4'b1011;
        tick(1);
        idle = 4'hF;
        tick(17);

        // Round robin: serve 1, then 0 and 3 together -> 3 first
        req = 4'h2;
        expect_at(2,  4'h2, 4'h0, 1'b1, "rr_g1");
        expect_at(4,  4'h2, 4'h2, 1'b1, "rr_ack1");
        expect_at(7,  4'hA, 4'h2, 1'b1, "rr_g3");
        expect_at(9,  4'hA, 4'hA, 1'b1, "rr_ack3");
        expect_at(10, 4'hA, 4'hA, 1'b1, "rr_wait0");
        expect_at(11, 4'hB, 4'hA, 1'b1, "rr_g0");
        expect_at(13, 4'hB, 4'hB, 1'b1, "rr_ack0");
        expect_at(14, 4'hB, 4'hB, 1'b0, "rr_done");
        tick(5);
        req = 4'b1011;
        tick(10);

        // test_en forces en only
        test_en = 1'b1;
        expect_at(0, 4'hF, 4'hB, 1'b0, "test_en_on");
        tick(1);
        test_en = 1'b0;
        expect_at(0, 4'hB, 4'hB, 1'b0, "test_en_off");
        tick(1);

        // Reset while domain 2 is settling
        req = 4'hF;
        expect_at(1, 4'hB, 4'hB, 1'b1, "rst_pend");
        expect_at(2, 4'hF, 4'hB, 1'b1, "rst_settle");
        expect_at(3, 4'h0, 4'h0, 1'b0, "rst_mid");
        tick(2);
        nreset = 1'b0;
        tick(1);
        req = 4'h0;
        tick(2);

        // Request withdrawn while pending -> no enable pulse
        nreset = 1'b1;
        tick(2);
        expect_at(0, 4'h0, 4'h0, 1'b0, "post_rst");
        req = 4'b0101;
        expect_at(1, 4'h0, 4'h0, 1'b1, "wd_pend");
        expect_at(2, 4'h1, 4'h0, 1'b1, "wd_g0");
        expect_at(4, 4'h1, 4'h1, 1'b1, "wd_ack0");
        expect_at(6, 4'h1, 4'h1, 1'b0, "wd_no_g2");
        expect_at(7, 4'h1, 4'h1, 1'b0, "wd_no_g2b");
        tick(2);
        req = 4'b0001;
        tick(6);

        tick(3);
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
            errors += q.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
